operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
// - Issue stage between decode and execute; reads sources from the 2R1W register file (1-cycle registered read).
// - Tracks pending destination writes in a scoreboard; stalls on RAW/WAW hazards.
// - Forwards same-cycle writeback data; delivers both operands to execute over a valid/ready handshake.
// PARAMETERS
// - INT32W        32  datapath width
// - REGFILE_SIZE  5   register address width (2**REGFILE_SIZE registers; x0 reads 0, never written)
// - PAYLOADW      64  opaque decode payload passed through unchanged (pc, imm, opcode)
// PORTS
// - clk          in   1             clock; all state on posedge
// - rst          in   1             async, active-high reset
// - flush        in   1             kill both stages (branch redirect)
// - in_valid     in   1             decoded instruction valid
// - in_ready     out  1             stage A can accept
// - in_rs1       in   REGFILE_SIZE  source 1 address
// - in_rs2       in   REGFILE_SIZE  source 2 address
// - in_rd        in   REGFILE_SIZE  destination address
// - in_rd_we     in   1             instruction writes rd
// - in_payload   in   PAYLOADW      pass-through
// - rf_rs1       out  REGFILE_SIZE  regfile read address 1 (= stage A rs1)
// - rf_rs2       out  REGFILE_SIZE  regfile read address 2 (= stage A rs2)
// - rf_data_rs1  in   INT32W        regfile read data 1 (valid the cycle after address)
// - rf_data_rs2  in   INT32W        regfile read data 2
// - wb_rd        in   REGFILE_SIZE  writeback address, same signal driving regfile rd (0 = no write)
// - wb_data      in   INT32W        writeback data
// - out_valid    out  1             operands valid to execute
// - out_ready    in   1             execute accepts
// - out_op1      out  INT32W        operand 1
// - out_op2      out  INT32W        operand 2
// - out_rd       out  REGFILE_SIZE  destination
// - out_rd_we    out  1             destination write enable
// - out_payload  out  PAYLOADW      pass-through
// BEHAVIOUR
// - Reset: A/B valid=0, busy[]=0, out_valid=0, out_op1/2=0, out_rd=0, out_rd_we=0, out_payload=0, in_ready=1 after release.
// - Stage A: in_ready = !flush & (!A_valid | adv); accept on in_valid&in_ready.
// - raw(rs) = rs!=0 & ((busy[rs] & wb_rd!=rs) | (B_valid & B_rd_we & B_rd==rs)).
// - waw = A_rd_we & A_rd!=0 & (busy[A_rd] | (B_valid & B_rd_we & B_rd==A_rd)); no early release for WAW.
// - adv = A_valid & !raw(rs1) & !raw(rs2) & !waw & (!B_valid | out_ready) & !flush.
// - On adv: B latches A fields; fwdN=(wb_rd!=0 & wb_rd==A_rsN), fwd value=wb_data (write missed by this read edge).
// - Stage B first cycle (fresh=1): opN = rsN==0 ? 0 : fwdN ? fwd_val : rf_data_rsN; copy into hold regs; later cycles drive hold regs.
// - Min latency in->out 2 cycles; 1 instr/cycle with no hazards and out_ready=1.
// - Output fires on out_valid&out_ready: if out_rd_we & out_rd!=0, set busy[out_rd].
// - Any wb_rd!=0 clears busy[wb_rd]; set and clear on same index same cycle -> set wins.
// - flush: A_valid=B_valid=0 next cycle, in_ready=0 that cycle, out_valid dropped; busy[] unchanged (issued writes still complete).
// - Reset mid-operation: all instructions lost, busy cleared; upstream must restart.
// - out_* stable while out_valid & !out_ready (except on flush).
// STRUCTURE
// - Shared defines header: `INT32W, `REGFILE_SIZE, PAYLOADW default; no new typedefs.
// - One sub-module: of_scoreboard (busy vector, set/clear ports, rs1/rs2/rd lookup).
// - Top: stage A regs, stage B regs + hold/forward mux, handshake logic.
// TESTING
// - Reset then in x1=5,x2=7 preset; issue add rd=3 rs1=1 rs2=2 -> out_valid cycle 2, op1=5, op2=7.
// - Issue rd=4 (busy[4]=1); next instr rs1=4 -> stalls, in_ready=0 until wb_rd=4,wb_data=0xAB; advances that cycle, op1=0xAB.
// - Back-to-back dependent: I0 rd=6, I1 rs1=6 -> I1 held in A while I0 in B; no out of I1 until busy[6] cleared.
// - out_ready=0 for 3 cycles with regfile rs addresses changing -> out_op1/op2 held constant, no drop/dup.
// - flush with A and B valid -> out_valid=0 next cycle, busy unchanged; rs=0 source with wb_rd=0 -> op=0.
// - WAW: busy[9]=1, new rd=9 -> stalls until wb_rd=9; simultaneous issue rd=9 & wb_rd=9 -> busy[9]=1.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand-fetch issue stage and its scoreboard.
// Module parameters default to these values so every file agrees on widths.
package operand_fetch_pkg;

    // Datapath width of one integer operand.
    localparam int DEF_INT32W       = 32;
    // Register address width; the file holds 2**DEF_REGFILE_SIZE registers.
    localparam int DEF_REGFILE_SIZE = 5;
    // Opaque decode payload (pc, imm, opcode) carried alongside the operands.
    localparam int DEF_PAYLOADW     = 64;

endpackage : operand_fetch_pkg

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A bit is set when an instruction that writes it leaves for execute and is
// cleared when writeback retires that register. x0 is never busy.
module of_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int REGFILE_SIZE = DEF_REGFILE_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_en,
    input  logic [REGFILE_SIZE-1:0] set_idx,
    input  logic [REGFILE_SIZE-1:0] clr_idx,
    input  logic [REGFILE_SIZE-1:0] rs1,
    input  logic [REGFILE_SIZE-1:0] rs2,
    input  logic [REGFILE_SIZE-1:0] rd,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rd_busy
);

    localparam int NUM_REGS = 2 ** REGFILE_SIZE;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear on writeback first, then set on issue so that
    // a same-index set and clear in one cycle leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_idx != '0) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register; reset forgets every outstanding write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign rd_busy  = busy_q[rd];

endmodule : of_scoreboard

// File: rtl/operand_fetch.sv
// Operand-fetch issue stage sitting between decode and execute.
// Stage A holds the decoded instruction while the register file is read and
// hazards are resolved; stage B presents both operands to execute over a
// valid/ready handshake, holding them stable until accepted.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int INT32W       = DEF_INT32W,
    parameter int REGFILE_SIZE = DEF_REGFILE_SIZE,
    parameter int PAYLOADW     = DEF_PAYLOADW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REGFILE_SIZE-1:0] in_rs1,
    input  logic [REGFILE_SIZE-1:0] in_rs2,
    input  logic [REGFILE_SIZE-1:0] in_rd,
    input  logic                    in_rd_we,
    input  logic [PAYLOADW-1:0]     in_payload,
    output logic [REGFILE_SIZE-1:0] rf_rs1,
    output logic [REGFILE_SIZE-1:0] rf_rs2,
    input  logic [INT32W-1:0]       rf_data_rs1,
    input  logic [INT32W-1:0]       rf_data_rs2,
    input  logic [REGFILE_SIZE-1:0] wb_rd,
    input  logic [INT32W-1:0]       wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT32W-1:0]       out_op1,
    output logic [INT32W-1:0]       out_op2,
    output logic [REGFILE_SIZE-1:0] out_rd,
    output logic                    out_rd_we,
    output logic [PAYLOADW-1:0]     out_payload
);

    // ---------------- Stage A state ----------------
    logic                    a_valid_q,   a_valid_d;
    logic [REGFILE_SIZE-1:0] a_rs1_q,     a_rs1_d;
    logic [REGFILE_SIZE-1:0] a_rs2_q,     a_rs2_d;
    logic [REGFILE_SIZE-1:0] a_rd_q,      a_rd_d;
    logic                    a_rd_we_q,   a_rd_we_d;
    logic [PAYLOADW-1:0]     a_payload_q, a_payload_d;

    // ---------------- Stage B state ----------------
    logic                    b_valid_q,   b_valid_d;
    logic [REGFILE_SIZE-1:0] b_rs1_q,     b_rs1_d;
    logic [REGFILE_SIZE-1:0] b_rs2_q,     b_rs2_d;
    logic [REGFILE_SIZE-1:0] b_rd_q,      b_rd_d;
    logic                    b_rd_we_q,   b_rd_we_d;
    logic [PAYLOADW-1:0]     b_payload_q, b_payload_d;
    logic                    b_fwd1_q,    b_fwd1_d;
    logic                    b_fwd2_q,    b_fwd2_d;
    logic [INT32W-1:0]       b_fwd_val_q, b_fwd_val_d;
    logic                    b_fresh_q,   b_fresh_d;
    logic [INT32W-1:0]       b_hold1_q,   b_hold1_d;
    logic [INT32W-1:0]       b_hold2_q,   b_hold2_d;

    // ---------------- Hazard / handshake nets ----------------
    logic              rs1_busy, rs2_busy, rd_busy;
    logic              b_claims_rs1, b_claims_rs2, b_claims_rd;
    logic              raw1, raw2, waw;
    logic              adv, accept, fire;
    logic [INT32W-1:0] op1_new, op2_new;

    of_scoreboard #(
        .REGFILE_SIZE (REGFILE_SIZE)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fire & b_rd_we_q),
        .set_idx  (b_rd_q),
        .clr_idx  (wb_rd),
        .rs1      (a_rs1_q),
        .rs2      (a_rs2_q),
        .rd       (a_rd_q),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // The register file is addressed straight from stage A; its registered
    // read lands in the cycle stage B first holds the instruction.
    assign rf_rs1 = a_rs1_q;
    assign rf_rs2 = a_rs2_q;

    // Hazard detection, advance and handshake decisions.
    always_comb begin
        // The instruction in B has not marked its rd busy yet, so it must be
        // checked explicitly alongside the scoreboard.
        b_claims_rs1 = b_valid_q & b_rd_we_q & (b_rd_q == a_rs1_q);
        b_claims_rs2 = b_valid_q & b_rd_we_q & (b_rd_q == a_rs2_q);
        b_claims_rd  = b_valid_q & b_rd_we_q & (b_rd_q == a_rd_q);

        // A busy source whose writeback arrives this cycle is released early
        // and picked up through the forward path.
        raw1 = (a_rs1_q != '0) & ((rs1_busy & (wb_rd != a_rs1_q)) | b_claims_rs1);
        raw2 = (a_rs2_q != '0) & ((rs2_busy & (wb_rd != a_rs2_q)) | b_claims_rs2);
        // WAW waits for the older write to fully retire (no early release).
        waw  = a_rd_we_q & (a_rd_q != '0) & (rd_busy | b_claims_rd);

        out_valid = b_valid_q & ~flush;
        fire      = out_valid & out_ready;
        adv       = a_valid_q & ~raw1 & ~raw2 & ~waw
                  & (~b_valid_q | out_ready) & ~flush;
        in_ready  = ~flush & (~a_valid_q | adv);
        accept    = in_valid & in_ready;
    end

    // Stage B operand select: the first cycle takes the fresh register-file
    // read (or a forwarded writeback that the read edge missed); afterwards
    // the captured copy keeps the outputs stable under backpressure.
    always_comb begin
        op1_new = (b_rs1_q == '0) ? '0 : (b_fwd1_q ? b_fwd_val_q : rf_data_rs1);
        op2_new = (b_rs2_q == '0) ? '0 : (b_fwd2_q ? b_fwd_val_q : rf_data_rs2);
        out_op1 = b_fresh_q ? op1_new : b_hold1_q;
        out_op2 = b_fresh_q ? op2_new : b_hold2_q;
    end

    assign out_rd      = b_rd_q;
    assign out_rd_we   = b_rd_we_q;
    assign out_payload = b_payload_q;

    // Stage A next state: load on accept, empty on advance or flush.
    always_comb begin
        a_valid_d   = a_valid_q;
        a_rs1_d     = a_rs1_q;
        a_rs2_d     = a_rs2_q;
        a_rd_d      = a_rd_q;
        a_rd_we_d   = a_rd_we_q;
        a_payload_d = a_payload_q;
        if (accept) begin
            a_valid_d   = 1'b1;
            a_rs1_d     = in_rs1;
            a_rs2_d     = in_rs2;
            a_rd_d      = in_rd;
            a_rd_we_d   = in_rd_we;
            a_payload_d = in_payload;
        end else if (adv) begin
            a_valid_d   = 1'b0;
        end
        if (flush) begin
            a_valid_d   = 1'b0;
        end
    end

    // Stage B next state: capture operands after the fresh cycle, load from
    // A on advance, retire on fire, and drop everything on flush.
    always_comb begin
        b_valid_d   = b_valid_q;
        b_rs1_d     = b_rs1_q;
        b_rs2_d     = b_rs2_q;
        b_rd_d      = b_rd_q;
        b_rd_we_d   = b_rd_we_q;
        b_payload_d = b_payload_q;
        b_fwd1_d    = b_fwd1_q;
        b_fwd2_d    = b_fwd2_q;
        b_fwd_val_d = b_fwd_val_q;
        b_fresh_d   = b_fresh_q;
        b_hold1_d   = b_hold1_q;
        b_hold2_d   = b_hold2_q;
        if (b_fresh_q) begin
            b_hold1_d = op1_new;
            b_hold2_d = op2_new;
            b_fresh_d = 1'b0;
        end
        if (adv) begin
            b_valid_d   = 1'b1;
            b_rs1_d     = a_rs1_q;
            b_rs2_d     = a_rs2_q;
            b_rd_d      = a_rd_q;
            b_rd_we_d   = a_rd_we_q;
            b_payload_d = a_payload_q;
            b_fwd1_d    = (wb_rd != '0) & (wb_rd == a_rs1_q);
            b_fwd2_d    = (wb_rd != '0) & (wb_rd == a_rs2_q);
            b_fwd_val_d = wb_data;
            b_fresh_d   = 1'b1;
        end else if (fire) begin
            b_valid_d   = 1'b0;
        end
        if (flush) begin
            b_valid_d   = 1'b0;
            b_fresh_d   = 1'b0;
        end
    end

    // Stage A register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q   <= 1'b0;
            a_rs1_q     <= '0;
            a_rs2_q     <= '0;
            a_rd_q      <= '0;
            a_rd_we_q   <= 1'b0;
            a_payload_q <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_rs1_q     <= a_rs1_d;
            a_rs2_q     <= a_rs2_d;
            a_rd_q      <= a_rd_d;
            a_rd_we_q   <= a_rd_we_d;
            a_payload_q <= a_payload_d;
        end
    end

    // Stage B register; data is cleared too so the outputs read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q   <= 1'b0;
            b_rs1_q     <= '0;
            b_rs2_q     <= '0;
            b_rd_q      <= '0;
            b_rd_we_q   <= 1'b0;
            b_payload_q <= '0;
            b_fwd1_q    <= 1'b0;
            b_fwd2_q    <= 1'b0;
            b_fwd_val_q <= '0;
            b_fresh_q   <= 1'b0;
            b_hold1_q   <= '0;
            b_hold2_q   <= '0;
        end else begin
            b_valid_q   <= b_valid_d;
            b_rs1_q     <= b_rs1_d;
            b_rs2_q     <= b_rs2_d;
            b_rd_q      <= b_rd_d;
            b_rd_we_q   <= b_rd_we_d;
            b_payload_q <= b_payload_d;
            b_fwd1_q    <= b_fwd1_d;
            b_fwd2_q    <= b_fwd2_d;
            b_fwd_val_q <= b_fwd_val_d;
            b_fresh_q   <= b_fresh_d;
            b_hold1_q   <= b_hold1_d;
            b_hold2_q   <= b_hold2_d;
        end
    end

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 2R1W register file
// (registered read, write visible from the following read edge).
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int W = DEF_INT32W;
    localparam int A = DEF_REGFILE_SIZE;
    localparam int P = DEF_PAYLOADW;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [A-1:0] in_rs1, in_rs2, in_rd;
    logic         in_rd_we;
    logic [P-1:0] in_payload;
    logic [A-1:0] rf_rs1, rf_rs2;
    logic [W-1:0] rf_data_rs1, rf_data_rs2;
    logic [A-1:0] wb_rd;
    logic [W-1:0] wb_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_op1, out_op2;
    logic [A-1:0] out_rd;
    logic         out_rd_we;
    logic [P-1:0] out_payload;

    logic [W-1:0] regs [0:(2**A)-1];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .in_payload  (in_payload),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .rf_data_rs1 (rf_data_rs1),
        .rf_data_rs2 (rf_data_rs2),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_payload (out_payload)
    );

    // Register file model: read-before-write, x0 never written.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**A; i++) regs[i] <= '0;
            rf_data_rs1 <= '0;
            rf_data_rs2 <= '0;
        end else begin
            rf_data_rs1 <= regs[rf_rs1];
            rf_data_rs2 <= regs[rf_rs2];
            if (wb_rd != '0) regs[wb_rd] <= wb_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic issue(input logic [A-1:0] rs1, input logic [A-1:0] rs2,
                         input logic [A-1:0] rd, input logic we, input logic [P-1:0] pl);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_rd_we   = we;
        in_payload = pl;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0; in_payload = '0;
        wb_rd = '0; wb_data = '0;

        // ---- reset ----
        repeat (3) nxt();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_op2", out_op2, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_rd_we", out_rd_we, 0);
        chk("rst_payload", out_payload, 0);
        rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);

        // ---- preset x1=5, x2=7 through writeback ----
        nxt(); wb_rd = 5'd1; wb_data = 32'd5;
        nxt(); wb_rd = 5'd2; wb_data = 32'd7;
        nxt(); wb_rd = '0;   wb_data = '0;

        // ---- T1: add x3 = x1 + x2, two-cycle latency ----
        issue(5'd1, 5'd2, 5'd3, 1'b1, 64'hA1);
        nxt(); idle(); #1 chk("t1_lat1_valid", out_valid, 0);
        nxt(); #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_op1", out_op1, 5);
        chk("t1_op2", out_op2, 7);
        chk("t1_rd", out_rd, 3);
        chk("t1_rd_we", out_rd_we, 1);
        chk("t1_payload", out_payload, 64'hA1);
        nxt(); #1 chk("t1_nodup", out_valid, 0);
        wb_rd = 5'd3; wb_data = 32'h33;

        // ---- T2: RAW on x4 with early release and forwarding ----
        nxt(); wb_rd = '0; wb_data = '0;
        issue(5'd0, 5'd0, 5'd4, 1'b1, 64'hA2);
        nxt(); issue(5'd4, 5'd1, 5'd0, 1'b0, 64'hB2);
        #1 chk("t2_accept_ib", in_ready, 1);
        nxt(); idle(); #1;
        chk("t2_ia_valid", out_valid, 1);
        chk("t2_ia_op1_x0", out_op1, 0);
        chk("t2_raw_in_b", in_ready, 0);
        nxt(); #1 chk("t2_raw_busy", in_ready, 0);
        chk("t2_no_out", out_valid, 0);
        nxt(); #1 chk("t2_raw_busy2", in_ready, 0);
        nxt(); wb_rd = 5'd4; wb_data = 32'hAB;
        #1 chk("t2_early_release", in_ready, 1);
        nxt(); wb_rd = '0; wb_data = '0; #1;
        chk("t2_ib_valid", out_valid, 1);
        chk("t2_ib_op1_fwd", out_op1, 32'hAB);
        chk("t2_ib_op2", out_op2, 5);
        chk("t2_ib_payload", out_payload, 64'hB2);

        // ---- T3: back-to-back dependent pair on x6 ----
        nxt(); issue(5'd1, 5'd2, 5'd6, 1'b1, 64'hC0);
        nxt(); issue(5'd6, 5'd0, 5'd7, 1'b1, 64'hC1);
        #1 chk("t3_accept_i1", in_ready, 1);
        nxt(); idle(); #1;
        chk("t3_i0_valid", out_valid, 1);
        chk("t3_i0_payload", out_payload, 64'hC0);
        chk("t3_i1_held_b", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            nxt(); #1;
            chk("t3_i1_no_out", out_valid, 0);
            chk("t3_i1_stalled", in_ready, 0);
        end
        nxt(); wb_rd = 5'd6; wb_data = 32'h66;
        nxt(); wb_rd = '0; wb_data = '0; #1;
        chk("t3_i1_valid", out_valid, 1);
        chk("t3_i1_op1", out_op1, 32'h66);
        chk("t3_i1_payload", out_payload, 64'hC1);
        chk("t3_i1_rd", out_rd, 7);
        nxt(); wb_rd = 5'd7; wb_data = 32'h77;

        // ---- T4: backpressure for three cycles while rf addresses change ----
        nxt(); wb_rd = '0; wb_data = '0;
        issue(5'd1, 5'd2, 5'd0, 1'b0, 64'hD0);
        nxt(); issue(5'd2, 5'd1, 5'd0, 1'b0, 64'hD1); out_ready = 1'b0;
        nxt(); idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_op1", out_op1, 5);
            chk("t4_hold_op2", out_op2, 7);
            chk("t4_hold_payload", out_payload, 64'hD0);
            nxt();
        end
        out_ready = 1'b1; #1;
        chk("t4_release_op1", out_op1, 5);
        chk("t4_release_payload", out_payload, 64'hD0);
        nxt(); #1;
        chk("t4_j1_valid", out_valid, 1);
        chk("t4_j1_op1", out_op1, 7);
        chk("t4_j1_op2", out_op2, 5);
        chk("t4_j1_payload", out_payload, 64'hD1);
        nxt(); #1 chk("t4_nodup", out_valid, 0);

        // ---- T5: mark x9 busy, then flush with A and B both full ----
        issue(5'd0, 5'd0, 5'd9, 1'b1, 64'hE0);
        nxt(); issue(5'd0, 5'd0, 5'd8, 1'b1, 64'hE1);
        nxt(); issue(5'd1, 5'd0, 5'd10, 1'b1, 64'hE2);
        nxt(); idle(); out_ready = 1'b0; #1;
        chk("t5_k0_valid", out_valid, 1);
        chk("t5_k0_payload", out_payload, 64'hE1);
        nxt(); flush = 1'b1; #1;
        chk("t5_flush_out_valid", out_valid, 0);
        chk("t5_flush_in_ready", in_ready, 0);
        nxt(); flush = 1'b0; out_ready = 1'b1; #1;
        chk("t5_after_out_valid", out_valid, 0);
        chk("t5_after_in_ready", in_ready, 1);
        issue(5'd8, 5'd0, 5'd0, 1'b0, 64'hE3);
        nxt(); idle(); #1 chk("t5_x8_not_busy", in_ready, 1);
        nxt(); #1;
        chk("t5_e3_valid", out_valid, 1);
        chk("t5_e3_payload", out_payload, 64'hE3);

        // ---- T6: WAW on x9 (busy kept across flush), then set-wins ----
        nxt(); issue(5'd0, 5'd0, 5'd9, 1'b1, 64'hF0);
        nxt(); idle(); #1 chk("t6_waw_stall", in_ready, 0);
        nxt(); wb_rd = 5'd9; wb_data = 32'h99;
        #1 chk("t6_waw_no_early", in_ready, 0);
        nxt(); wb_rd = '0; wb_data = '0;
        #1 chk("t6_waw_release", in_ready, 1);
        nxt(); wb_rd = 5'd9; wb_data = 32'h55; #1;
        chk("t6_m_valid", out_valid, 1);
        chk("t6_m_rd", out_rd, 9);
        chk("t6_m_payload", out_payload, 64'hF0);
        nxt(); wb_rd = '0; wb_data = '0;
        issue(5'd0, 5'd0, 5'd9, 1'b1, 64'hF1);
        nxt(); idle(); #1 chk("t6_set_wins", in_ready, 0);
        nxt(); #1 chk("t6_set_wins2", in_ready, 0);
        nxt(); wb_rd = 5'd9; wb_data = 32'h1;
        nxt(); wb_rd = '0; wb_data = 32'hFFFF_FFFF;
        #1 chk("t6_n_release", in_ready, 1);
        nxt(); wb_data = '0; #1;
        chk("t6_n_valid", out_valid, 1);
        chk("t6_x0_op1", out_op1, 0);
        chk("t6_x0_op2", out_op2, 0);
        chk("t6_n_payload", out_payload, 64'hF1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_operand_fetch
